// File: rtl/kernel_dispatch_top.sv
// kernel_dispatch_top: NUM_CH kernel start/ready channels behind a job/result stream.
// Optional per-channel watchdog is compiled in with `define ACCEL_TIMEOUT_EN.
module kernel_dispatch_top #(
    parameter int NUM_CH      = 2,
    parameter int RET_W       = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    job_valid,
    output logic                    job_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [RET_W-1:0]        res_ret,
    output logic [CH_W-1:0]         res_ch,
    output logic [CNT_W-1:0]        res_cycles,
    output logic                    res_err,
    output logic                    busy,
    output logic [NUM_CH-1:0]       k_start,
    input  logic [NUM_CH-1:0]       k_ready,
    input  logic [NUM_CH*RET_W-1:0] k_ret
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(DEPTH + NUM_CH + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } ch_state_e;

    ch_state_e        st_q  [NUM_CH];
    ch_state_e        st_d  [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [RET_W-1:0] ret_q [NUM_CH];
    logic [RET_W-1:0] ret_d [NUM_CH];
    logic             err_q [NUM_CH];
    logic             err_d [NUM_CH];
    logic             run_q;

    logic [RET_W-1:0] fret_q [DEPTH];
    logic [CH_W-1:0]  fch_q  [DEPTH];
    logic [CNT_W-1:0] fcyc_q [DEPTH];
    logic             ferr_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    wr_d;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rd_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic             any_idle;
    logic             any_done;
    logic [CH_W-1:0]  idle_sel;
    logic [CH_W-1:0]  done_sel;
    logic [OW-1:0]    active;
    logic [OW-1:0]    occ;
    logic             accept;
    logic             push;
    logic             pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Downward scan leaves the lowest matching index selected.
    always_comb begin
        any_idle = 1'b0;
        any_done = 1'b0;
        idle_sel = '0;
        done_sel = '0;
        active   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (st_q[i] == S_IDLE) begin
                any_idle = 1'b1;
                idle_sel = CH_W'(i);
            end
            if (st_q[i] == S_DONE) begin
                any_done = 1'b1;
                done_sel = CH_W'(i);
            end
            if (st_q[i] != S_IDLE) begin
                active = active + OW'(1);
            end
        end
    end

    // Busy channels hold a reserved FIFO slot, so a DONE entry always fits.
    assign occ       = OW'(count_q) + active;
    assign job_ready = run_q && any_idle && (occ < OW'(DEPTH));
    assign accept    = job_valid && job_ready;
    assign push      = any_done;
    assign res_valid = (count_q != '0);
    assign pop       = res_valid && res_ready;
    assign busy      = (active != '0) || res_valid;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            k_start[i] = (st_q[i] == S_START);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            ret_d[i] = ret_q[i];
            err_d[i] = err_q[i];
            unique case (st_q[i])
                S_IDLE: begin
                    if (accept && (idle_sel == CH_W'(i))) begin
                        st_d[i]  = S_START;
                        cnt_d[i] = '0;
                        ret_d[i] = '0;
                        err_d[i] = 1'b0;
                    end
                end
                S_START: begin
                    st_d[i]  = S_RUN;
                    cnt_d[i] = CNT_W'(1);
                end
                S_RUN: begin
                    if (k_ready[i]) begin
                        st_d[i]  = S_DONE;
                        ret_d[i] = k_ret[i*RET_W +: RET_W];
                    end
`ifdef ACCEL_TIMEOUT_EN
                    else if (cnt_q[i] == TO_LIM) begin
                        st_d[i]  = S_DONE;
                        ret_d[i] = '0;
                        err_d[i] = 1'b1;
                    end
`endif
                    else if (cnt_q[i] != '1) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (push && (done_sel == CH_W'(i))) begin
                        st_d[i] = S_IDLE;
                    end
                end
                default: st_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
                ret_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            run_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                ret_q[i] <= ret_d[i];
                err_q[i] <= err_d[i];
            end
        end
    end

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            wr_d = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                fret_q[j] <= '0;
                fch_q[j]  <= '0;
                fcyc_q[j] <= '0;
                ferr_q[j] <= 1'b0;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (push) begin
                fret_q[wr_q] <= ret_q[done_sel];
                fch_q[wr_q]  <= done_sel;
                fcyc_q[wr_q] <= cnt_q[done_sel];
                ferr_q[wr_q] <= err_q[done_sel];
            end
        end
    end

    assign res_ret    = fret_q[rd_q];
    assign res_ch     = fch_q[rd_q];
    assign res_cycles = fcyc_q[rd_q];

`ifdef ACCEL_TIMEOUT_EN
    assign res_err = ferr_q[rd_q];
`else
    logic unused_to;
    logic unused_ferr;
    assign unused_to   = ^TO_LIM;
    assign unused_ferr = ferr_q[rd_q];
    assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_dispatch_top.sv
// Directed scoreboard bench for kernel_dispatch_top (NUM_CH=2, DEPTH=8).
// The watchdog case runs only when ACCEL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
`define CK(tag, o, e) chk(tag, 128'(o), 128'(e))
module tb_kernel_dispatch_top;

    localparam int NUM_CH = 2;
    localparam int RET_W  = 32;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 1;

    logic                    clk       = 1'b0;
    logic                    reset     = 1'b0;
    logic                    job_valid = 1'b0;
    logic                    res_ready = 1'b1;
    logic [NUM_CH-1:0]       k_ready   = '0;
    logic [NUM_CH*RET_W-1:0] k_ret     = '0;
    logic                    job_ready;
    logic                    res_valid;
    logic                    res_err;
    logic                    busy;
    logic [RET_W-1:0]        res_ret;
    logic [CH_W-1:0]         res_ch;
    logic [CNT_W-1:0]        res_cycles;
    logic [NUM_CH-1:0]       k_start;

    typedef struct packed {
        logic [31:0] ret;
        logic        ch;
        logic [31:0] cyc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;
    int          cyc    = 0;
    int          st[NUM_CH];
    int          dl[NUM_CH];
    logic [31:0] rv[NUM_CH];
    int          jobn   = 0;
    bit          auto_en = 1'b0;
    int          acc;
    int          g;

    kernel_dispatch_top #(
        .NUM_CH(NUM_CH),
        .RET_W(RET_W),
        .DEPTH(8),
        .CNT_W(CNT_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_ret(res_ret),
        .res_ch(res_ch),
        .res_cycles(res_cycles),
        .res_err(res_err),
        .busy(busy),
        .k_start(k_start),
        .k_ready(k_ready),
        .k_ret(k_ret)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start-cycle capture and result-stream scoreboard check.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset && k_start[i]) st[i] = cyc;
        end
        if (reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                total++;
                failed++;
                $error("FAIL unexpected_result: observed ch=%0d ret=%0h expected none",
                       res_ch, res_ret);
            end else begin
                mon_e = sb.pop_front();
                `CK("result", {res_ret, res_ch, res_cycles, res_err}, mon_e);
            end
        end
    end

    // Auto kernel: answers 3 cycles after start with ret 0x100+job.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                k_ready[i] = 1'b0;
                if (k_start[i]) begin
                    dl[i] = 3;
                    rv[i] = 32'h100 + 32'(jobn);
                    jobn++;
                    sb.push_back(exp_t'{rv[i], 1'(i), 32'd3, 1'b0});
                end else if (dl[i] > 0) begin
                    dl[i]--;
                    if (dl[i] == 0) begin
                        k_ready[i] = 1'b1;
                        k_ret[i*RET_W +: RET_W] = rv[i];
                    end
                end
            end
        end
    endtask

    task automatic launch();
        int n;
        n = 0;
        job_valid = 1'b1;
        while (!job_ready && n < 100) begin
            step();
            n++;
        end
        `CK("launch_accept", job_ready, 1'b1);
        step();
        job_valid = 1'b0;
    endtask

    task automatic kready(input logic [1:0] m, input logic [31:0] r0,
                          input logic [31:0] r1);
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) begin
                k_ready[i] = 1'b1;
                k_ret[i*RET_W +: RET_W] = (i == 0) ? r0 : r1;
                sb.push_back(exp_t'{((i == 0) ? r0 : r1), 1'(i),
                                    32'(cyc - st[i]), 1'b0});
            end
        end
        step();
        k_ready = '0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            dl[i] = 0;
            st[i] = 0;
            rv[i] = '0;
        end
        repeat (3) step();
        `CK("rst_outputs", {job_ready, res_valid, res_ret, res_ch, res_cycles,
                            res_err, busy, k_start}, 0);
        reset = 1'b1;
        `CK("rst_release_job_ready", job_ready, 1'b0);
        step();
        `CK("job_ready_after_reset", job_ready, 1'b1);

        // Single job, 5-cycle kernel.
        launch();
        `CK("t1_kstart", k_start, 2'b01);
        step();
        `CK("t1_kstart_once", k_start, 2'b00);
        repeat (4) step();
        kready(2'b01, 32'h1234, 32'h0);
        `CK("t1_res_valid_m1", res_valid, 1'b0);
        step();
        `CK("t1_res_valid_m2", res_valid, 1'b1);
        step();
        `CK("t1_busy_idle", busy, 1'b0);
        `CK("t1_sb_empty", sb.size(), 0);

        // Three back-to-back jobs on two channels.
        job_valid = 1'b1;
        acc = 0;
        g = 0;
        while (acc < 2 && g < 50) begin
            if (job_ready) acc++;
            step();
            g++;
        end
        `CK("t2_two_accepts", acc, 2);
        `CK("t2_job_ready_full", job_ready, 1'b0);
        `CK("t2_kstart_ch1", k_start, 2'b10);
        repeat (3) step();
        kready(2'b01, 32'h11, 32'h0);
        `CK("t2_ready_done", job_ready, 1'b0);
        step();
        `CK("t2_ready_idle", job_ready, 1'b1);
        step();
        job_valid = 1'b0;
        `CK("t2_third_start", k_start, 2'b01);
        repeat (2) step();

        // Both kernels complete in the same cycle.
        kready(2'b11, 32'hA, 32'hB);
        step();
        `CK("t3_head_ch0", {res_ch, res_ret}, {1'b0, 32'hA});
        step();
        `CK("t3_head_ch1", {res_ch, res_ret}, {1'b1, 32'hB});
        step();
        `CK("t3_busy_idle", busy, 1'b0);
        `CK("t3_sb_empty", sb.size(), 0);

        // Credit limit with a stalled result port, then 20 jobs total.
        res_ready = 1'b0;
        auto_en   = 1'b1;
        job_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 40; n++) begin
            if (job_valid && job_ready) acc++;
            step();
        end
        `CK("t4_accepts_depth", acc, 8);
        `CK("t4_job_ready_full", job_ready, 1'b0);
        `CK("t4_res_valid", res_valid, 1'b1);
        job_valid = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        `CK("t4_job_ready_after_pop", job_ready, 1'b1);
        res_ready = 1'b1;
        job_valid = 1'b1;
        g = 0;
        while (acc < 20 && g < 300) begin
            if (job_ready) acc++;
            step();
            g++;
        end
        job_valid = 1'b0;
        `CK("t4_accepts_total", acc, 20);
        repeat (20) step();
        `CK("t4_sb_empty", sb.size(), 0);
        `CK("t4_busy_idle", busy, 1'b0);

        // Reset in the middle of a run with queued results.
        res_ready = 1'b0;
        job_valid = 1'b1;
        acc = 0;
        g = 0;
        while (acc < 3 && g < 50) begin
            if (job_ready) acc++;
            step();
            g++;
        end
        job_valid = 1'b0;
        repeat (6) step();
        auto_en = 1'b0;
        k_ready = '0;
        `CK("t5_queued", {res_valid, busy}, 2'b11);
        launch();
        repeat (2) step();
        #2 reset = 1'b0;
        #1;
        `CK("t5_rst_outputs", {job_ready, res_valid, res_ret, res_ch, res_cycles,
                               res_err, busy, k_start}, 0);
        sb.delete();
        repeat (2) step();
        reset = 1'b1;
        k_ready[0] = 1'b1;
        k_ret[0 +: RET_W] = 32'hDEAD;
        step();
        k_ready = '0;
        repeat (3) step();
        `CK("t5_late_ready_ignored", {res_valid, busy, k_start}, 0);
        res_ready = 1'b1;

`ifdef ACCEL_TIMEOUT_EN
        // Watchdog: kernel never answers.
        launch();
        sb.push_back(exp_t'{32'h0, 1'b0, 32'd16, 1'b1});
        repeat (17) step();
        `CK("t6_res_valid_pre", res_valid, 1'b0);
        step();
        `CK("t6_res_valid", res_valid, 1'b1);
        step();
        k_ready[0] = 1'b1;
        k_ret[0 +: RET_W] = 32'hBEEF;
        step();
        k_ready = '0;
        repeat (4) step();
        `CK("t6_late_ready_ignored", {res_valid, busy}, 2'b00);
        `CK("t6_sb_empty", sb.size(), 0);
`endif

        `CK("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "bench time limit");
    end

endmodule
